// File: rtl/wb_commit_arbiter.sv
// rtl/wb_commit_arbiter.sv - round-robin writeback arbiter, NUM_UNITS requesters onto NUM_PORTS commit ports
// Optional registered commit output: WB_ARB_REGISTERED_OUTPUT_EN.

package wb_commit_arbiter_pkg;
    typedef logic [5:0] id_t;
    typedef logic [5:0] phys_addr_t;

    typedef struct packed {
        logic       valid;
        id_t        id;
        phys_addr_t phys_addr;
        logic [31:0] data;
    } commit_packet_t;
endpackage

module wb_commit_arbiter
    import wb_commit_arbiter_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int NUM_PORTS = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 writeback_supress,
    input  logic [NUM_UNITS-1:0]                 unit_done,
    input  id_t [NUM_UNITS-1:0]                  unit_id,
    input  phys_addr_t [NUM_UNITS-1:0]           unit_phys_addr,
    input  logic [NUM_UNITS-1:0][31:0]           unit_data,
    output logic [NUM_UNITS-1:0]                 unit_ack,
    output commit_packet_t [NUM_PORTS-1:0]       commit
);

    localparam int PTR_W = $clog2(NUM_UNITS);
    localparam int CNT_W = $clog2(NUM_PORTS + 1);

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_ptr_next;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] last_idx;
    logic [CNT_W-1:0] cnt;
    logic             rst_d;
    logic             block;
    logic             any_grant;
    commit_packet_t [NUM_PORTS-1:0] comb_commit;

    // Grants are also held off for one cycle after reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_d  <= 1'b1;
            rr_ptr <= '0;
        end else begin
            rst_d  <= 1'b0;
            rr_ptr <= rr_ptr_next;
        end
    end

    always_comb begin
        unit_ack    = '0;
        comb_commit = '0;
        cnt         = '0;
        idx         = '0;
        last_idx    = rr_ptr;
        any_grant   = 1'b0;
        block       = rst | rst_d | writeback_supress;
        for (int i = 0; i < NUM_UNITS; i++) begin
            idx = PTR_W'((int'(rr_ptr) + i) % NUM_UNITS);
            if (!block && unit_done[idx] && (cnt < CNT_W'(NUM_PORTS))) begin
                unit_ack[idx] = 1'b1;
                // k-th grant in scan order lands on port k, so idle ports stay on top
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (cnt == CNT_W'(p)) begin
                        comb_commit[p].valid     = 1'b1;
                        comb_commit[p].id        = unit_id[idx];
                        comb_commit[p].phys_addr = unit_phys_addr[idx];
                        comb_commit[p].data      = unit_data[idx];
                    end
                end
                cnt       = cnt + CNT_W'(1);
                last_idx  = idx;
                any_grant = 1'b1;
            end
        end
        rr_ptr_next = any_grant ? PTR_W'((int'(last_idx) + 1) % NUM_UNITS) : rr_ptr;
    end

`ifdef WB_ARB_REGISTERED_OUTPUT_EN
    commit_packet_t [NUM_PORTS-1:0] commit_q;

    // Suppressed cycles carry valid=0 in comb_commit, so the next edge clears the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_q <= '0;
        end else begin
            commit_q <= comb_commit;
        end
    end

    always_comb begin
        commit = commit_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (rst) begin
                commit[p].valid = 1'b0;
            end
        end
    end
`else
    assign commit = comb_commit;
`endif

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// tb/tb_wb_commit_arbiter.sv - directed and random checks for wb_commit_arbiter (4 units, 2 ports)
module tb_wb_commit_arbiter;
    import wb_commit_arbiter_pkg::*;

`ifdef WB_ARB_REGISTERED_OUTPUT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic                  clk;
    logic                  rst;
    logic                  writeback_supress;
    logic [3:0]            unit_done;
    id_t [3:0]             unit_id;
    phys_addr_t [3:0]      unit_phys_addr;
    logic [3:0][31:0]      unit_data;
    logic [3:0]            unit_ack;
    commit_packet_t [1:0]  commit;

    int checks;
    int failures;
    int pend0;
    int pend1;

    wb_commit_arbiter #(.NUM_UNITS(4), .NUM_PORTS(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .writeback_supress (writeback_supress),
        .unit_done         (unit_done),
        .unit_id           (unit_id),
        .unit_phys_addr    (unit_phys_addr),
        .unit_data         (unit_data),
        .unit_ack          (unit_ack),
        .commit            (commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_port(input int p, input int eu);
        check($sformatf("port%0d_valid", p), commit[p].valid, (eu >= 0));
        if (eu >= 0) begin
            check($sformatf("port%0d_payload", p),
                  {commit[p].id, commit[p].phys_addr, commit[p].data},
                  {unit_id[eu], unit_phys_addr[eu], unit_data[eu]});
        end
    endtask

    // e0/e1: unit expected on commit[0]/[1] for grants of this cycle (-1 = none); eptr: rr_ptr during this cycle
    task automatic step(input logic r, input logic s, input logic [3:0] d,
                        input logic [3:0] eack, input int e0, input int e1, input int eptr);
        int c0;
        int c1;
        @(posedge clk);
        #1;
        rst = r;
        writeback_supress = s;
        unit_done = d;
        #4;
        check("ack", unit_ack, eack);
        check("rr_ptr", dut.rr_ptr, eptr);
        if (LAT == 0) begin
            c0 = e0;
            c1 = e1;
        end else begin
            c0 = r ? -1 : pend0;
            c1 = r ? -1 : pend1;
        end
        pend0 = e0;
        pend1 = e1;
        check_port(0, c0);
        check_port(1, c1);
    endtask

    initial begin
        logic [3:0] rdone;
        int waitc [4];
        int max_wait;
        int acks;
        int commits;
        int bad_ack;

        checks = 0;
        failures = 0;
        pend0 = -1;
        pend1 = -1;
        rst = 1'b1;
        writeback_supress = 1'b0;
        unit_done = 4'b0000;
        unit_id        = {6'd7, 6'd5, 6'd2, 6'd1};
        unit_phys_addr = {6'd20, 6'd9, 6'd18, 6'd17};
        unit_data      = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h1000_0000};

        // reset with a request in flight, then single request from unit 2
        step(1, 0, 4'b0100, 4'b0000, -1, -1, 0);
        step(1, 0, 4'b0100, 4'b0000, -1, -1, 0);
        step(0, 0, 4'b0100, 4'b0000, -1, -1, 0);
        step(0, 0, 4'b0100, 4'b0100,  2, -1, 0);
        // wrap-around from rr_ptr=3
        step(0, 0, 4'b1001, 4'b1001,  3,  0, 3);
        step(0, 0, 4'b1000, 4'b1000,  3, -1, 1);
        // all four requesting
        step(0, 0, 4'b1111, 4'b0011,  0,  1, 0);
        step(0, 0, 4'b1111, 4'b1100,  2,  3, 2);
        step(0, 0, 4'b1111, 4'b0011,  0,  1, 0);
        // suppress
        step(0, 1, 4'b0110, 4'b0000, -1, -1, 2);
        step(0, 1, 4'b0110, 4'b0000, -1, -1, 2);
        step(0, 0, 4'b0110, 4'b0110,  2,  1, 2);
        step(0, 0, 4'b0111, 4'b0101,  2,  0, 2);
        // reset mid-stream
        step(1, 0, 4'b0111, 4'b0000, -1, -1, 1);
        step(1, 0, 4'b0111, 4'b0000, -1, -1, 0);
        step(0, 0, 4'b0111, 4'b0000, -1, -1, 0);
        step(0, 0, 4'b0111, 4'b0011,  0,  1, 0);
        step(0, 0, 4'b0000, 4'b0000, -1, -1, 2);

        // random requests held until acked
        rdone = 4'b0000;
        max_wait = 0;
        acks = 0;
        commits = 0;
        bad_ack = 0;
        for (int u = 0; u < 4; u++) waitc[u] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(posedge clk);
            #1;
            for (int u = 0; u < 4; u++) begin
                if (!rdone[u] && ($urandom_range(0, 1) == 1)) begin
                    rdone[u] = 1'b1;
                    waitc[u] = 0;
                end
            end
            unit_done = rdone;
            #4;
            if ((unit_ack & ~rdone) != 4'b0000) bad_ack++;
            for (int u = 0; u < 4; u++) begin
                if (rdone[u]) begin
                    waitc[u]++;
                    if (unit_ack[u]) begin
                        if (waitc[u] > max_wait) max_wait = waitc[u];
                        acks++;
                        rdone[u] = 1'b0;
                    end
                end
            end
            for (int p = 0; p < 2; p++) if (commit[p].valid) commits++;
        end
        for (int cyc = 0; cyc < 2; cyc++) begin
            @(posedge clk);
            #1;
            unit_done = 4'b0000;
            #4;
            for (int p = 0; p < 2; p++) if (commit[p].valid) commits++;
        end
        check("ack_without_done", bad_ack, 0);
        check("max_wait_le_2", (max_wait <= 2), 1);
        check("acks_seen", (acks > 0), 1);
        check("commit_eq_ack", commits, acks);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
